rst_stream_checker: RTL and testbench

- Synthesizable receive-side checker for the valid/data streams produced by the reset-style pipelines (rst_all, rst_bad, rst_good).
- Samples LANES parallel valid/data lanes fed by the same stimulus, and checks that all lanes agree beat-for-beat and that data increments monotonically.
- Declares pass or fail after the burst has drained, so reset-style comparisons run on silicon/FPGA without a simulator bench.

---
 rtl/rst_test_pkg.sv | 9 +
 rtl/rst_lane_compare.sv | 24 ++
 rtl/rst_stream_checker.sv | 122 ++++++++++++
 tb/tb_rst_stream_checker.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rst_test_pkg.sv
// Shared state encoding and failure codes for the reset-style stream checker.
package rst_test_pkg;
  typedef enum logic [2:0] {IDLE, BURST, DRAIN, DONE, FAIL} state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_SKEW = 2'd1;
  localparam logic [1:0] ERR_DATA = 2'd2;
  localparam logic [1:0] ERR_INC  = 2'd3;
endpackage

// File: rtl/rst_lane_compare.sv
// Combinational classification of one sample across all lanes: beat/gap/skew
// plus per-lane disagreement masks against lane 0.
module rst_lane_compare #(
  parameter int LANES = 3,
  parameter int DW    = 4
) (
  input  logic [LANES-1:0]    valid,
  input  logic [LANES*DW-1:0] data,
  output logic                beat,
  output logic                gap,
  output logic                skew,
  output logic [LANES-1:0]    data_mask,
  output logic [LANES-1:0]    valid_mask
);
  assign beat = &valid;
  assign gap  = ~|valid;
  assign skew = ~beat & ~gap;

  // Lane 0 is the reference, so bit 0 of both masks is always 0.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign data_mask[k]  = (data[k*DW +: DW] != data[DW-1:0]);
    assign valid_mask[k] = valid[k] ^ valid[0];
  end
endmodule

// File: rtl/rst_stream_checker.sv
// Receive-side checker: lanes must agree beat-for-beat and, optionally, count up
// by one; declares done after the burst drains or fails on the first violation.
module rst_stream_checker
  import rst_test_pkg::*;
#(
  parameter int LANES        = 3,
  parameter int DW           = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter bit CHECK_INC    = 1'b1,
  parameter int CNT_W        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LANES-1:0]    valid_i,
  input  logic [LANES*DW-1:0] data_i,
  output logic                done_o,
  output logic                error_o,
  output logic [1:0]          err_code_o,
  output logic [LANES-1:0]    err_lanes_o,
  output logic [CNT_W-1:0]    beat_cnt_o
);
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  state_e           state, state_nxt;
  logic [DCW-1:0]   drain_cnt, drain_nxt;
  logic [DW-1:0]    prev, prev_nxt;
  logic             prev_vld, prev_vld_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       code_nxt;
  logic [LANES-1:0] lanes_nxt;

  logic             beat, gap, skew, do_beat;
  logic [LANES-1:0] data_mask, valid_mask;
  logic [DW-1:0]    d0;

  assign d0 = data_i[DW-1:0];

  rst_lane_compare #(.LANES(LANES), .DW(DW)) u_cmp (
    .valid      (valid_i),
    .data       (data_i),
    .beat       (beat),
    .gap        (gap),
    .skew       (skew),
    .data_mask  (data_mask),
    .valid_mask (valid_mask)
  );

  always_comb begin
    state_nxt    = state;
    drain_nxt    = drain_cnt;
    prev_nxt     = prev;
    prev_vld_nxt = prev_vld;
    cnt_nxt      = beat_cnt_o;
    code_nxt     = err_code_o;
    lanes_nxt    = err_lanes_o;
    do_beat      = 1'b0;

    case (state)
      IDLE, BURST, DRAIN: begin
        if (skew) begin
          state_nxt = FAIL;
          code_nxt  = ERR_SKEW;
          lanes_nxt = valid_mask;
        end else if (beat) begin
          do_beat = 1'b1;
        end else if (gap) begin
          if (state == BURST) begin
            state_nxt = DRAIN;
            drain_nxt = DCW'(1);
          end else if (state == DRAIN) begin
            if (drain_cnt == DCW'(DRAIN_CYCLES)) state_nxt = DONE;
            else                                 drain_nxt = drain_cnt + DCW'(1);
          end
        end
      end
      default: ;
    endcase

    // A failing beat is never counted and never becomes the new reference.
    if (do_beat) begin
      if (|data_mask) begin
        state_nxt = FAIL;
        code_nxt  = ERR_DATA;
        lanes_nxt = data_mask;
      end else if (CHECK_INC && prev_vld && (d0 != prev + DW'(1))) begin
        state_nxt = FAIL;
        code_nxt  = ERR_INC;
        lanes_nxt = '0;
      end else begin
        state_nxt    = BURST;
        drain_nxt    = '0;
        prev_nxt     = d0;
        prev_vld_nxt = 1'b1;
        if (beat_cnt_o != '1) cnt_nxt = beat_cnt_o + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      drain_cnt   <= '0;
      prev        <= '0;
      prev_vld    <= 1'b0;
      beat_cnt_o  <= '0;
      err_code_o  <= ERR_NONE;
      err_lanes_o <= '0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
    end else begin
      state       <= state_nxt;
      drain_cnt   <= drain_nxt;
      prev        <= prev_nxt;
      prev_vld    <= prev_vld_nxt;
      beat_cnt_o  <= cnt_nxt;
      err_code_o  <= code_nxt;
      err_lanes_o <= lanes_nxt;
      done_o      <= (state_nxt == DONE);
      error_o     <= (state_nxt == FAIL);
    end
  end
endmodule

// File: tb/tb_rst_stream_checker.sv
// Scoreboard bench: stimulus pushes the reference model's expected outputs,
// a monitor pops and compares one entry per clock.
module tb_rst_stream_checker;
  localparam int LANES = 3, DW = 4, DRAIN = 3, CNT_W = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [LANES-1:0]    valid_i = '0;
  logic [LANES*DW-1:0] data_i = '0;
  logic                done_o, error_o;
  logic [1:0]          err_code_o;
  logic [LANES-1:0]    err_lanes_o;
  logic [CNT_W-1:0]    beat_cnt_o;

  always #5 clk = ~clk;

  rst_stream_checker #(.LANES(LANES), .DW(DW), .DRAIN_CYCLES(DRAIN),
                       .CHECK_INC(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i),
    .done_o(done_o), .error_o(error_o), .err_code_o(err_code_o),
    .err_lanes_o(err_lanes_o), .beat_cnt_o(beat_cnt_o)
  );

  typedef struct {
    logic             done, err;
    logic [1:0]       code;
    logic [LANES-1:0] lanes;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_fail = 0;

  // Reference model state: plain flags and integers following the stream rules.
  bit         m_fail, m_done, m_started, m_have_prev;
  int         m_gaps, m_cnt, m_prev;
  int         m_code;
  logic [2:0] m_lanes;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_fail(input int code, input logic [2:0] lanes);
    m_fail = 1; m_code = code; m_lanes = lanes;
  endtask

  task automatic model_reset();
    m_fail = 0; m_done = 0; m_started = 0; m_have_prev = 0;
    m_gaps = 0; m_cnt = 0; m_prev = 0; m_code = 0; m_lanes = '0;
  endtask

  task automatic model(input bit r, input logic [2:0] v, input logic [11:0] d);
    int          ln [3];
    logic [2:0]  mm;
    for (int k = 0; k < 3; k++) ln[k] = int'(d[k*4 +: 4]);
    if (!r) model_reset();
    else if (!m_fail && !m_done) begin
      if (v == 3'b111) begin
        mm = '0;
        for (int k = 1; k < 3; k++) if (ln[k] != ln[0]) mm[k] = 1'b1;
        if (mm != 0) model_fail(2, mm);
        else if (m_have_prev && ln[0] != (m_prev + 1) % 16) model_fail(3, 3'b000);
        else begin
          m_prev = ln[0]; m_have_prev = 1; m_started = 1; m_gaps = 0;
          if (m_cnt < 255) m_cnt++;
        end
      end else if (v == 3'b000) begin
        if (m_started) begin
          m_gaps++;
          if (m_gaps == DRAIN + 1) m_done = 1;
        end
      end else model_fail(1, v ^ {3{v[0]}});
    end
  endtask

  task automatic step(input bit r, input logic [2:0] v, input logic [3:0] a,
                      input logic [3:0] b, input logic [3:0] c);
    exp_t e;
    @(negedge clk);
    rst_n = r; valid_i = v; data_i = {c, b, a};
    model(r, v, {c, b, a});
    e.done = m_done; e.err = m_fail; e.code = 2'(m_code);
    e.lanes = m_lanes; e.cnt = 8'(m_cnt);
    q.push_back(e);
  endtask

  task automatic beat(input int d);
    step(1, 3'b111, 4'(d), 4'(d), 4'(d));
  endtask

  task automatic gaps(input int n);
    for (int i = 0; i < n; i++) step(1, 3'b000, 4'(i), 4'(i + 3), 4'(i + 7));
  endtask

  task automatic do_reset();
    step(0, 3'b000, 4'h0, 4'h0, 4'h0);
    step(0, 3'b000, 4'h0, 4'h0, 4'h0);
  endtask

  // Directed checks against fixed expectations, sampled mid-cycle.
  task automatic expect_out(input string tag, input int d, input int e,
                            input int code, input int cnt);
    @(negedge clk);
    chk({tag, ".done"}, int'(done_o), d);
    chk({tag, ".error"}, int'(error_o), e);
    chk({tag, ".code"}, int'(err_code_o), code);
    chk({tag, ".cnt"}, int'(beat_cnt_o), cnt);
  endtask

  // Monitor: every clock the DUT presents a fresh registered result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb.done",  int'(done_o),      int'(e.done));
        chk("sb.error", int'(error_o),     int'(e.err));
        chk("sb.code",  int'(err_code_o),  int'(e.code));
        chk("sb.lanes", int'(err_lanes_o), int'(e.lanes));
        chk("sb.cnt",   int'(beat_cnt_o),  int'(e.cnt));
        if (e.done && e.err) chk("sb.done_and_error", 1, 0);
      end
    end
  end

  initial begin
    int d, len, kind;
    model_reset();
    #2;
    chk("reset.done", int'(done_o), 0);
    chk("reset.error", int'(error_o), 0);
    chk("reset.cnt", int'(beat_cnt_o), 0);
    do_reset();

    // Clean burst, done on the 4th cycle after the last beat.
    beat(7); beat(8); beat(9); beat(10);
    gaps(3);
    expect_out("clean.pre", 0, 0, 0, 4);
    gaps(2);
    expect_out("clean", 1, 0, 0, 4);
    beat(11); step(1, 3'b010, 4'h1, 4'h2, 4'h3);
    expect_out("clean.after_done", 1, 0, 0, 4);

    // Lane 1 disagrees on the second beat.
    do_reset();
    beat(7); step(1, 3'b111, 4'h8, 4'h9, 4'h8);
    expect_out("mismatch", 0, 1, 2, 1);
    chk("mismatch.lanes", int'(err_lanes_o), 3'b010);
    beat(9); step(1, 3'b001, 4'h0, 4'h0, 4'h0); gaps(6);
    expect_out("mismatch.frozen", 0, 1, 2, 1);

    // Valid skew mid-burst.
    do_reset();
    beat(1); beat(2); step(1, 3'b101, 4'h3, 4'h3, 4'h3); beat(4); gaps(6);
    expect_out("skew", 0, 1, 1, 2);

    // Wrap is legal, a skipped value is not.
    do_reset();
    beat(14); beat(15); beat(0); beat(1); gaps(5);
    expect_out("wrap", 1, 0, 0, 4);
    do_reset();
    beat(3); beat(5);
    expect_out("incbreak", 0, 1, 3, 1);

    // Short gap inside a burst keeps the increment chain.
    do_reset();
    beat(2); beat(3); gaps(2);
    expect_out("gapburst.mid", 0, 0, 0, 2);
    beat(4); beat(5); gaps(5);
    expect_out("gapburst", 1, 0, 0, 4);

    // Asynchronous reset mid-burst, next burst starts fresh.
    do_reset();
    beat(1); beat(2);
    @(posedge clk); #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async.done", int'(done_o), 0);
    chk("async.error", int'(error_o), 0);
    chk("async.cnt", int'(beat_cnt_o), 0);
    step(0, 3'b000, 4'h0, 4'h0, 4'h0);
    beat(9); beat(10); gaps(5);
    expect_out("async.next", 1, 0, 0, 2);

    // Counter saturation.
    do_reset();
    for (int i = 0; i < 260; i++) beat(i % 16);
    gaps(5);
    expect_out("saturate", 1, 0, 0, 255);

    // Randomized bursts with occasional injected faults.
    for (int t = 0; t < 30; t++) begin
      do_reset();
      d   = int'($urandom_range(0, 15));
      len = int'($urandom_range(1, 12));
      for (int b = 0; b < len; b++) begin
        kind = int'($urandom_range(0, 15));
        case (kind)
          0: step(1, 3'b111, 4'(d), 4'(d), 4'(d + $urandom_range(1, 15)));
          1: step(1, 3'(1 << $urandom_range(0, 2)), 4'(d), 4'(d), 4'(d));
          2: beat(d + int'($urandom_range(2, 15)));
          3: gaps(int'($urandom_range(1, 4)));
          default: beat(d);
        endcase
        d = (d + 1) % 16;
      end
      gaps(int'($urandom_range(3, 6)));
      beat(int'($urandom_range(0, 15)));
      gaps(2);
    end

    repeat (3) @(negedge clk);
    chk("sb.queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
